doy_to_date: RTL and testbench

//  Converts a day-of-year count plus a leap-year flag into calendar month and day-of-month.
//  It is the inverse of the month-length lookup: it walks months Jan..Dec, subtracting each

---
 rtl/calendar_pkg.sv | 30 +++
 rtl/month_len_lut.sv | 23 ++
 rtl/doy_to_date.sv | 133 +++++++++++++
 tb/tb_doy_to_date.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/calendar_pkg.sv
// Shared calendar types and constants.
//   month_t : 4-bit month number, 1..12 (0 = none)
//   dom_t   : 5-bit day of month, 1..31 (0 = none)
//   doy_t   : 9-bit day of year
//   state_t : day-of-year walker FSM states
package calendar_pkg;

  typedef logic [3:0] month_t;
  typedef logic [4:0] dom_t;
  typedef logic [8:0] doy_t;

  localparam month_t JAN = 4'd1;
  localparam month_t FEB = 4'd2;
  localparam month_t MAR = 4'd3;
  localparam month_t APR = 4'd4;
  localparam month_t MAY = 4'd5;
  localparam month_t JUN = 4'd6;
  localparam month_t JUL = 4'd7;
  localparam month_t AUG = 4'd8;
  localparam month_t SEP = 4'd9;
  localparam month_t OCT = 4'd10;
  localparam month_t NOV = 4'd11;
  localparam month_t DEC = 4'd12;

  localparam int DAYS_YEAR = 365;
  localparam int DAYS_LEAP = 366;

  typedef enum logic {IDLE, WALK} state_t;

endpackage

// File: rtl/month_len_lut.sv
// Combinational month-length lookup.
//   month : 1..12 (anything else returns 0)
//   leap  : 1 = February has 29 days
//   days  : length of the month in days
module month_len_lut
  import calendar_pkg::*;
(
  input  month_t     month,
  input  logic       leap,
  output logic [5:0] days
);

  always_comb begin
    days = 6'd0;
    case (month)
      JAN, MAR, MAY, JUL, AUG, OCT, DEC: days = 6'd31;
      APR, JUN, SEP, NOV:                days = 6'd30;
      FEB:                               days = leap ? 6'd29 : 6'd28;
      default:                           days = 6'd0;
    endcase
  end

endmodule

// File: rtl/doy_to_date.sv
// Day-of-year to calendar date converter.
// Walks Jan..Dec subtracting month lengths from the latched day count until
// the remainder fits in the current month; one month per clock.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   start      : request, sampled only while busy=0
//   doy_in     : day of year (1-based if ONE_BASED=1, else 0-based)
//   leap_year  : 1 = 366-day year
//   busy       : walk in progress, start ignored
//   done       : one-cycle pulse, month/day/err valid
//   err        : last request was out of range
//   month, day : result (0/0 on error or reset)
module doy_to_date
  import calendar_pkg::*;
#(
  parameter bit ONE_BASED = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] doy_in,
  input  logic       leap_year,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] month,
  output logic [4:0] day
);

  state_t state_q, state_d;
  doy_t   rem_q, rem_d;
  month_t cur_m_q, cur_m_d;
  logic   leap_q, leap_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   err_q, err_d;
  month_t month_q, month_d;
  dom_t   day_q, day_d;

  logic [5:0] len;

  // 10 bits so a 0-based 511 normalizes to 512 and is still rejected.
  logic [9:0] norm;
  logic [9:0] limit;

  assign norm  = {1'b0, doy_in} + (ONE_BASED ? 10'd0 : 10'd1);
  assign limit = leap_year ? 10'(DAYS_LEAP) : 10'(DAYS_YEAR);

  month_len_lut u_lut (
    .month (cur_m_q),
    .leap  (leap_q),
    .days  (len)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cur_m_d = cur_m_q;
    leap_d  = leap_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    month_d = month_q;
    day_d   = day_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          leap_d = leap_year;
          rem_d  = norm[8:0];
          if (norm == 10'd0 || norm > limit) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            month_d = '0;
            day_d   = '0;
          end else begin
            cur_m_d = JAN;
            busy_d  = 1'b1;
            err_d   = 1'b0;
            state_d = WALK;
          end
        end
      end
      WALK: begin
        if (rem_q <= {3'b000, len}) begin
          month_d = cur_m_q;
          day_d   = rem_q[4:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          // rem > len here, so no underflow
          rem_d   = rem_q - {3'b000, len};
          cur_m_d = cur_m_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cur_m_q <= '0;
      leap_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      month_q <= '0;
      day_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cur_m_q <= cur_m_d;
      leap_q  <= leap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      month_q <= month_d;
      day_q   <= day_d;
    end
  end

  // Range check bounds the December remainder, so the walk never passes DEC.
  a_dec_fits: assert property (@(posedge clk) disable iff (reset)
    (state_q == WALK && cur_m_q == DEC) |-> (rem_q <= 9'd31));

  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign month = month_q;
  assign day   = day_q;

endmodule

// File: tb/tb_doy_to_date.sv
module tb_doy_to_date;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a, start_b;
  logic [8:0] doy_in;
  logic       leap_year;
  logic       busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [3:0] month_a, month_b;
  logic [4:0] day_a, day_b;

  always #5 clk = ~clk;

  doy_to_date #(.ONE_BASED(1'b1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .doy_in(doy_in),
    .leap_year(leap_year), .busy(busy_a), .done(done_a), .err(err_a),
    .month(month_a), .day(day_a)
  );

  doy_to_date #(.ONE_BASED(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .doy_in(doy_in),
    .leap_year(leap_year), .busy(busy_b), .done(done_b), .err(err_b),
    .month(month_b), .day(day_b)
  );

  typedef struct {
    int m;
    int d;
    int e;
    int lat;
  } exp_t;

  exp_t sb_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic set_start(input bit b, input logic v);
    if (b) start_b = v;
    else   start_a = v;
  endtask

  // Called at a negedge: pulses start for one cycle; returns at the negedge
  // after the accepting edge (latency count 1).
  task automatic issue(input bit b, input int doy, input bit leap,
                       input int m, input int d, input int e, input int lat);
    exp_t x;
    x.m = m; x.d = d; x.e = e; x.lat = lat;
    sb_q.push_back(x);
    doy_in    = 9'(doy);
    leap_year = leap;
    set_start(b, 1'b1);
    @(negedge clk);
    set_start(b, 1'b0);
  endtask

  // Waits for done, pops the scoreboard and compares. Optionally fires a new
  // start in the done cycle itself.
  task automatic collect(input bit b, input string tag, input int cyc0,
                         input bit chain, input int doy2, input bit leap2,
                         input int m2, input int d2, input int e2, input int lat2);
    int   cyc;
    logic dn;
    exp_t x;
    cyc = cyc0;
    dn  = b ? done_b : done_a;
    while (!dn && cyc < 30) begin
      @(negedge clk);
      cyc++;
      dn = b ? done_b : done_a;
    end
    if (!dn) begin
      chk({tag, "_timeout"}, int'(dn), 1);
      return;
    end
    chk({tag, "_sb_nonempty"}, int'(sb_q.size() > 0), 1);
    if (sb_q.size() == 0) return;
    x = sb_q.pop_front();
    chk({tag, "_lat"},   cyc, x.lat);
    chk({tag, "_month"}, int'(b ? month_b : month_a), x.m);
    chk({tag, "_day"},   int'(b ? day_b : day_a), x.d);
    chk({tag, "_err"},   int'(b ? err_b : err_a), x.e);
    chk({tag, "_busy"},  int'(b ? busy_b : busy_a), 0);
    if (chain) begin
      x.m = m2; x.d = d2; x.e = e2; x.lat = lat2;
      sb_q.push_back(x);
      doy_in    = 9'(doy2);
      leap_year = leap2;
      set_start(b, 1'b1);
    end
    @(negedge clk);
    set_start(b, 1'b0);
    chk({tag, "_pulse1"}, int'(b ? done_b : done_a), 0);
  endtask

  task automatic req(input bit b, input string tag, input int doy, input bit leap,
                     input int m, input int d, input int e, input int lat);
    issue(b, doy, leap, m, d, e, lat);
    collect(b, tag, 1, 1'b0, 0, 1'b0, 0, 0, 0, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; doy_in = '0; leap_year = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  int'(busy_a),  0);
    chk("rst_done",  int'(done_a),  0);
    chk("rst_err",   int'(err_a),   0);
    chk("rst_month", int'(month_a), 0);
    chk("rst_day",   int'(day_a),   0);
    chk("rst_b_done", int'(done_b), 0);
    reset = 1'b0;
    @(negedge clk);

    // One-based instance
    req(0, "jan1",   1,   0, 1,  1,  0, 2);
    req(0, "d60n",   60,  0, 3,  1,  0, 4);
    req(0, "d60l",   60,  1, 2,  29, 0, 3);
    req(0, "d59n",   59,  0, 2,  28, 0, 3);
    req(0, "d32",    32,  0, 2,  1,  0, 3);
    // Dec 31 with a back-to-back start in its done cycle
    issue(0, 365, 0, 12, 31, 0, 13);
    collect(0, "d365n", 1, 1'b1, 366, 1'b1, 12, 31, 0, 13);
    collect(0, "d366l_b2b", 1, 1'b0, 0, 1'b0, 0, 0, 0, 0);
    req(0, "e366n",  366, 0, 0,  0,  1, 1);
    req(0, "d200",   200, 0, 7,  19, 0, 8);
    req(0, "e0",     0,   0, 0,  0,  1, 1);
    req(0, "e400",   400, 1, 0,  0,  1, 1);

    // Zero-based instance
    req(1, "z0",     0,   0, 1,  1,  0, 2);
    req(1, "z365l",  365, 1, 12, 31, 0, 13);
    req(1, "ze366l", 366, 1, 0,  0,  1, 1);
    req(1, "ze511",  511, 0, 0,  0,  1, 1);
    req(1, "z364n",  364, 0, 12, 31, 0, 13);

    // Start while busy is ignored
    issue(0, 100, 0, 4, 10, 0, 5);
    @(negedge clk);
    @(negedge clk);
    chk("busy_hi", int'(busy_a), 1);
    doy_in = 9'd5; leap_year = 1'b0; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    collect(0, "busy_d100", 4, 1'b0, 0, 1'b0, 0, 0, 0, 0);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_a) n++;
    end
    chk("busy_no_extra_done", n, 0);
    chk("busy_sb_empty", sb_q.size(), 0);

    // Reset mid-walk aborts with no done
    doy_in = 9'd300; leap_year = 1'b0; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    chk("walk_busy", int'(busy_a), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy",  int'(busy_a),  0);
    chk("abort_month", int'(month_a), 0);
    chk("abort_day",   int'(day_a),   0);
    chk("abort_done",  int'(done_a),  0);
    n = 0;
    repeat (15) begin
      @(negedge clk);
      if (done_a) n++;
    end
    chk("abort_no_done", n, 0);
    req(0, "d300", 300, 0, 10, 27, 0, 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
